// File: rtl/dot_scan_controller.sv
// dot_scan_controller
//
// Walks a row/column address across a dot matrix. Each dot gets one SETTLE
// cycle, so dot_sequencer can present firing_bit/firing_data for the new
// address. That cycle is followed by a DWELL window of max(dwell_cycles,1)
// cycles. A registered drive pulse (fire_out) is high for the first
// min(pulse_cycles, dwell) DWELL cycles when the dot is enabled.
//
// Configuration macro:
//   DOT_SCAN_SERPENTINE_EN - when defined, odd rows scan col_count down to 0.
//
// Ports:
//   clock, reset          sole clock (rising edge), async active-high reset
//   start, stop           scan request (IDLE only) / abort request (any state)
//   row_count, col_count  last row / column index to scan (sampled live)
//   dwell_cycles          DWELL length per dot (0 behaves as 1)
//   pulse_cycles          drive pulse width per dot (0 = no pulse)
//   firing_bit/data       dot enable and data from dot_sequencer
//   row_select/col_select current dot address
//   advance               one-cycle strobe after each address load
//   fire_out              registered motor drive pulse
//   busy                  high in SETTLE/DWELL
//   done                  one-cycle strobe after the final dot completes
module dot_scan_controller #(
    parameter int unsigned MEM_ADDRESS_LENGTH = 7,
    parameter int unsigned TIMER_WIDTH        = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic [MEM_ADDRESS_LENGTH-1:0] row_count,
    input  logic [MEM_ADDRESS_LENGTH-1:0] col_count,
    input  logic [TIMER_WIDTH-1:0]        dwell_cycles,
    input  logic [TIMER_WIDTH-1:0]        pulse_cycles,
    input  logic                          firing_bit,
    input  logic                          firing_data,
    output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
    output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
    output logic                          advance,
    output logic                          fire_out,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned AW = MEM_ADDRESS_LENGTH;
    localparam int unsigned TW = TIMER_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StDwell
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] row_q, row_d;
    logic [AW-1:0] col_q, col_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          fire_en_q, fire_en_d;
    logic          fire_out_q, fire_out_d;
    logic          advance_q, advance_d;
    logic          done_q, done_d;

    logic          dwell_last;
    logic          final_dot;
    logic [AW-1:0] end_col;
    logic [AW-1:0] step_row;
    logic [AW-1:0] step_col;
    logic [TW:0]   timer_inc;

    // A zero dwell is treated as a one-cycle dwell.
    assign dwell_last = (dwell_cycles == '0) || (timer_q >= dwell_cycles - TW'(1));

    // One bit wider so the pulse comparison cannot wrap.
    assign timer_inc = {1'b0, timer_q} + 1'b1;

`ifdef DOT_SCAN_SERPENTINE_EN
    // Odd rows run backwards, so their last dot sits at column 0.
    assign end_col = row_q[0] ? '0 : col_count;

    always_comb begin
        step_row = row_q;
        step_col = col_q;
        if (row_q[0]) begin
            if (col_q != '0) begin
                step_col = col_q - AW'(1);
            end else begin
                step_row = row_q + AW'(1);
                step_col = '0;
            end
        end else begin
            if (col_q < col_count) begin
                step_col = col_q + AW'(1);
            end else begin
                // Next row is odd: it starts from the far end.
                step_row = row_q + AW'(1);
                step_col = col_count;
            end
        end
    end
`else
    assign end_col = col_count;

    always_comb begin
        step_row = row_q;
        step_col = col_q;
        if (col_q < col_count) begin
            step_col = col_q + AW'(1);
        end else begin
            step_row = row_q + AW'(1);
            step_col = '0;
        end
    end
`endif

    assign final_dot = (row_q == row_count) && (col_q == end_col);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        timer_d    = timer_q;
        fire_en_d  = fire_en_q;
        fire_out_d = 1'b0;
        advance_d  = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    row_d     = '0;
                    col_d     = '0;
                    advance_d = 1'b1;
                    state_d   = StSettle;
                end
            end
            StSettle: begin
                if (stop) begin
                    state_d = StIdle;
                end else begin
                    fire_en_d  = firing_bit & firing_data;
                    timer_d    = '0;
                    state_d    = StDwell;
                    // First DWELL cycle has timer 0, so it fires for any nonzero width.
                    fire_out_d = fire_en_d && (pulse_cycles != '0);
                end
            end
            StDwell: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (dwell_last) begin
                    timer_d = '0;
                    if (final_dot) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        row_d     = step_row;
                        col_d     = step_col;
                        advance_d = 1'b1;
                        state_d   = StSettle;
                    end
                end else begin
                    timer_d    = timer_inc[TW-1:0];
                    fire_out_d = fire_en_q && (timer_inc < {1'b0, pulse_cycles});
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            timer_q    <= '0;
            fire_en_q  <= 1'b0;
            fire_out_q <= 1'b0;
            advance_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            timer_q    <= timer_d;
            fire_en_q  <= fire_en_d;
            fire_out_q <= fire_out_d;
            advance_q  <= advance_d;
            done_q     <= done_d;
        end
    end

    assign row_select = row_q;
    assign col_select = col_q;
    assign advance    = advance_q;
    assign fire_out   = fire_out_q;
    assign done       = done_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_dot_scan_controller.sv
// Self-checking bench for dot_scan_controller. The expected behaviour comes
// from scan geometry: the dot visiting order is built with nested loops. The
// waveform of each output is derived from a cycle offset since start, with
// each dot taking dwell+1 cycles.
module tb_dot_scan_controller;

    localparam int AW = 7;
    localparam int TW = 16;

    logic          clock;
    logic          reset;
    logic          start;
    logic          stop;
    logic [AW-1:0] row_count;
    logic [AW-1:0] col_count;
    logic [TW-1:0] dwell_cycles;
    logic [TW-1:0] pulse_cycles;
    logic          firing_bit;
    logic          firing_data;
    logic [AW-1:0] row_select;
    logic [AW-1:0] col_select;
    logic          advance;
    logic          fire_out;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    dot_scan_controller #(
        .MEM_ADDRESS_LENGTH(AW),
        .TIMER_WIDTH       (TW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .row_count   (row_count),
        .col_count   (col_count),
        .dwell_cycles(dwell_cycles),
        .pulse_cycles(pulse_cycles),
        .firing_bit  (firing_bit),
        .firing_data (firing_data),
        .row_select  (row_select),
        .col_select  (col_select),
        .advance     (advance),
        .fire_out    (fire_out),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " advance"}, 32'(advance), 0);
        check({tag, " fire_out"}, 32'(fire_out), 0);
    endtask

    // fire_mode: 0 = always enabled, 1 = data low, 2 = random enables plus
    // random start pulses while busy. stop_at / rst_at: cycle offset at which
    // to abort (negative = never).
    task automatic run_scan(input int rc, input int cc, input int dw, input int pu,
                            input int fire_mode, input int stop_at, input int rst_at);
        int d, p_on, n, total;
        int er[$];
        int ec[$];
        bit fen[$];
        d    = (dw == 0) ? 1 : dw;
        p_on = (pu < d) ? pu : d;
        for (int r = 0; r <= rc; r++) begin
            for (int i = 0; i <= cc; i++) begin
`ifdef DOT_SCAN_SERPENTINE_EN
                ec.push_back((r % 2 == 1) ? cc - i : i);
`else
                ec.push_back(i);
`endif
                er.push_back(r);
            end
        end
        n     = er.size();
        total = n * (d + 1);

        row_count    = AW'(rc);
        col_count    = AW'(cc);
        dwell_cycles = TW'(dw);
        pulse_cycles = TW'(pu);
        @(negedge clock);
        start = 1'b1;
        stop  = 1'b0;
        for (int s = 0; s <= total; s++) begin
            int  k;
            int  ph;
            bit  exp_fire;
            bit  fb;
            bit  fd;
            @(negedge clock);
            if (s == 0) start = 1'b0;
            if (stop_at >= 0 && s == stop_at + 1) begin
                check_idle($sformatf("stop s=%0d", s));
                stop = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clock);
                    check_idle($sformatf("after stop %0d", j));
                end
                return;
            end
            k        = (s < total) ? s / (d + 1) : n - 1;
            ph       = s % (d + 1);
            exp_fire = (s < total) && ph >= 1 && ph <= p_on && fen[k];
            check($sformatf("advance s=%0d", s), 32'(advance), 32'(s < total && ph == 0));
            check($sformatf("busy s=%0d", s), 32'(busy), 32'(s < total));
            check($sformatf("done s=%0d", s), 32'(done), 32'(s == total));
            check($sformatf("fire_out s=%0d", s), 32'(fire_out), 32'(exp_fire));
            check($sformatf("row s=%0d", s), 32'(row_select), 32'(er[k]));
            check($sformatf("col s=%0d", s), 32'(col_select), 32'(ec[k]));
            if (rst_at >= 0 && s == rst_at) begin
                #2 reset = 1'b1;
                #1;
                check_idle("async reset");
                check("async reset row", 32'(row_select), 0);
                check("async reset col", 32'(col_select), 0);
                @(negedge clock);
                reset = 1'b0;
                check_idle("post reset");
                return;
            end
            if (s < total && ph == 0) begin
                fb = (fire_mode == 2) ? 1'($urandom % 2) : 1'b1;
                fd = (fire_mode == 0) ? 1'b1 : (fire_mode == 1) ? 1'b0 : 1'($urandom % 2);
                firing_bit  = fb;
                firing_data = fd;
                fen.push_back(fb & fd);
            end
            if (s == stop_at) stop = 1'b1;
            if (fire_mode == 2) start = (s < total) ? 1'($urandom % 2) : 1'b0;
        end
        start = 1'b0;
        @(negedge clock);
        check_idle("post done");
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        row_count    = '0;
        col_count    = '0;
        dwell_cycles = '0;
        pulse_cycles = '0;
        firing_bit   = 1'b0;
        firing_data  = 1'b0;
        @(negedge clock);
        check_idle("reset");
        check("reset row", 32'(row_select), 0);
        check("reset col", 32'(col_select), 0);
        reset = 1'b0;

        run_scan(1, 2, 4, 2, 0, -1, -1);   // 2x3 scan, full drive
        run_scan(1, 2, 4, 2, 1, -1, -1);   // same timing, no drive
        run_scan(0, 0, 0, 5, 0, -1, -1);   // single dot, zero dwell
        run_scan(1, 2, 4, 2, 0, 8, -1);    // abort on 3rd DWELL cycle of dot 1
        run_scan(1, 2, 4, 2, 0, -1, -1);   // restart from (0,0)

        // start and stop together in IDLE: stop wins
        @(negedge clock);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        check_idle("start+stop");
        @(negedge clock);
        check_idle("start+stop hold");

        run_scan(1, 2, 4, 3, 0, -1, 7);    // async reset mid-pulse

        for (int i = 0; i < 10; i++) begin
            run_scan(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 6)), 2, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
